// File: rtl/spi_config_bunny.sv
// PCD8544 (Nokia 5110) SPI driver: sends the controller init sequence, then
// streams 504-byte frames built from a sprite ROM and a hunger bar in bank 5.
module spi_config_bunny #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned INIT_DELAY = 16
) (
    input  logic       clock,
    input  logic       Reset,
    input  logic [3:0] nivel_hambre,
    input  logic [3:0] draw,
    output logic       mosi,
    output logic       sclk,
    output logic       sce,
    output logic       dc
);
    localparam int unsigned CW = $clog2(2 * CLK_DIV + 1);
    localparam int unsigned WW = $clog2(INIT_DELAY + 1);
    localparam logic [CW-1:0] PH_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(2 * CLK_DIV - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(INIT_DELAY - 1);

    typedef enum logic [2:0] {S_WAIT, S_INIT, S_SET_ADDR, S_DATA, S_IDLE} state_t;
    typedef enum logic [2:0] {PH_IDLE, PH_LOAD, PH_LOW, PH_HIGH, PH_GAP} phase_t;

    state_t        state, state_n;
    phase_t        phase, phase_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    sr, sr_n;
    logic [WW-1:0] wait_cnt, wait_n;
    logic [2:0]    seq_idx, idx_n;
    logic [2:0]    bank, bank_n;
    logic [6:0]    col, col_n;
    logic [3:0]    draw_q, hunger_q;
    logic [3:0]    frame_draw, fdraw_n, frame_hunger, fhunger_n;
    logic          mosi_n, sclk_n, sce_n, dc_n;
    logic          free, load, load_dc;
    logic [7:0]    load_byte, data_byte;
    logic [6:0]    bar_len;

    function automatic logic [7:0] init_cmd(input logic [2:0] i);
        case (i)
            3'd0:    init_cmd = 8'h21;
            3'd1:    init_cmd = 8'hBF;
            3'd2:    init_cmd = 8'h04;
            3'd3:    init_cmd = 8'h14;
            3'd4:    init_cmd = 8'h20;
            default: init_cmd = 8'h0C;
        endcase
    endfunction

    // Sprite 1 is the bunny (ears, body with eyes, feet); sprite 2 a dither test pattern.
    function automatic logic [7:0] sprite_byte(input logic [3:0] idx, input logic [2:0] b,
                                               input logic [6:0] c);
        logic ears, body, eyes, feet;
        ears = (c >= 7'd30 && c <= 7'd33) || (c >= 7'd50 && c <= 7'd53);
        body = (c >= 7'd26 && c <= 7'd57);
        eyes = (c >= 7'd34 && c <= 7'd35) || (c >= 7'd48 && c <= 7'd49);
        feet = (c >= 7'd28 && c <= 7'd33) || (c >= 7'd50 && c <= 7'd55);
        sprite_byte = 8'h00;
        case (idx)
            4'd1: begin
                case (b)
                    3'd0:    sprite_byte = ears ? 8'hF0 : 8'h00;
                    3'd1:    sprite_byte = ears ? 8'hFF : 8'h00;
                    3'd2:    sprite_byte = body ? (eyes ? 8'hE7 : 8'hFF) : 8'h00;
                    3'd3:    sprite_byte = body ? 8'hFF : 8'h00;
                    3'd4:    sprite_byte = feet ? 8'h0F : 8'h00;
                    default: sprite_byte = 8'h00;
                endcase
            end
            4'd2:    sprite_byte = c[0] ? 8'h55 : 8'hAA;
            default: sprite_byte = 8'h00;
        endcase
    endfunction

    always_comb begin
        bar_len = {3'b000, frame_hunger} * 7'd5;
        if (bank == 3'd5)
            data_byte = (col < bar_len) ? 8'h3C : 8'h00;
        else if (frame_draw == 4'd0)
            data_byte = 8'h00;
        else
            data_byte = sprite_byte(frame_draw, bank, col);
    end

    always_comb begin
        state_n   = state;
        phase_n   = phase;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        sr_n      = sr;
        wait_n    = wait_cnt;
        idx_n     = seq_idx;
        bank_n    = bank;
        col_n     = col;
        fdraw_n   = frame_draw;
        fhunger_n = frame_hunger;
        mosi_n    = mosi;
        sclk_n    = sclk;
        sce_n     = sce;
        dc_n      = dc;
        load      = 1'b0;
        load_byte = 8'h00;
        load_dc   = 1'b0;
        // Next byte is chosen on the last gap clock so bytes run back to back.
        free      = (phase == PH_IDLE) || (phase == PH_GAP && cnt == GAP_LAST);

        case (state)
            S_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    load      = 1'b1;
                    load_byte = init_cmd(3'd0);
                    idx_n     = 3'd1;
                    wait_n    = '0;
                    state_n   = S_INIT;
                end else begin
                    wait_n = wait_cnt + WW'(1);
                end
            end
            S_INIT: begin
                if (free) begin
                    load = 1'b1;
                    if (seq_idx == 3'd6) begin
                        load_byte = 8'h80;
                        fdraw_n   = draw_q;
                        fhunger_n = hunger_q;
                        bank_n    = '0;
                        col_n     = '0;
                        idx_n     = 3'd1;
                        state_n   = S_SET_ADDR;
                    end else begin
                        load_byte = init_cmd(seq_idx);
                        idx_n     = seq_idx + 3'd1;
                    end
                end
            end
            S_SET_ADDR: begin
                if (free) begin
                    load = 1'b1;
                    if (seq_idx == 3'd1) begin
                        load_byte = 8'h40;
                        idx_n     = 3'd2;
                    end else begin
                        load_byte = data_byte;
                        load_dc   = 1'b1;
                        col_n     = 7'd1;
                        state_n   = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (free) begin
                    if (bank == 3'd6) begin
                        state_n = S_IDLE;
                    end else begin
                        load      = 1'b1;
                        load_byte = data_byte;
                        load_dc   = 1'b1;
                        if (col == 7'd83) begin
                            col_n  = '0;
                            bank_n = bank + 3'd1;
                        end else begin
                            col_n = col + 7'd1;
                        end
                    end
                end
            end
            S_IDLE: begin
                if (free && (draw_q != frame_draw || hunger_q != frame_hunger)) begin
                    load      = 1'b1;
                    load_byte = 8'h80;
                    fdraw_n   = draw_q;
                    fhunger_n = hunger_q;
                    bank_n    = '0;
                    col_n     = '0;
                    idx_n     = 3'd1;
                    state_n   = S_SET_ADDR;
                end
            end
            default: state_n = S_WAIT;
        endcase

        if (load) begin
            phase_n   = PH_LOAD;
            cnt_n     = '0;
            bit_cnt_n = '0;
            sr_n      = {load_byte[6:0], 1'b0};
            mosi_n    = load_byte[7];
            dc_n      = load_dc;
            sce_n     = 1'b0;
            sclk_n    = 1'b0;
        end else begin
            case (phase)
                PH_LOAD: begin
                    phase_n = PH_LOW;
                    cnt_n   = '0;
                end
                PH_LOW: begin
                    if (cnt == PH_LAST) begin
                        phase_n = PH_HIGH;
                        sclk_n  = 1'b1;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                PH_HIGH: begin
                    if (cnt == PH_LAST) begin
                        cnt_n  = '0;
                        sclk_n = 1'b0;
                        if (bit_cnt == 3'd7) begin
                            phase_n = PH_GAP;
                            sce_n   = 1'b1;
                        end else begin
                            phase_n   = PH_LOW;
                            mosi_n    = sr[7];
                            sr_n      = {sr[6:0], 1'b0};
                            bit_cnt_n = bit_cnt + 3'd1;
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                PH_GAP: begin
                    if (cnt == GAP_LAST) begin
                        phase_n = PH_IDLE;
                        cnt_n   = '0;
                        mosi_n  = 1'b0;
                        dc_n    = 1'b0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: phase_n = PH_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state        <= S_WAIT;
            phase        <= PH_IDLE;
            cnt          <= '0;
            bit_cnt      <= '0;
            sr           <= '0;
            wait_cnt     <= '0;
            seq_idx      <= '0;
            bank         <= '0;
            col          <= '0;
            draw_q       <= '0;
            hunger_q     <= '0;
            frame_draw   <= '0;
            frame_hunger <= '0;
            mosi         <= 1'b0;
            sclk         <= 1'b0;
            sce          <= 1'b1;
            dc           <= 1'b0;
        end else begin
            state        <= state_n;
            phase        <= phase_n;
            cnt          <= cnt_n;
            bit_cnt      <= bit_cnt_n;
            sr           <= sr_n;
            wait_cnt     <= wait_n;
            seq_idx      <= idx_n;
            bank         <= bank_n;
            col          <= col_n;
            draw_q       <= draw;
            hunger_q     <= nivel_hambre;
            frame_draw   <= fdraw_n;
            frame_hunger <= fhunger_n;
            mosi         <= mosi_n;
            sclk         <= sclk_n;
            sce          <= sce_n;
            dc           <= dc_n;
        end
    end
endmodule

// File: tb/tb_spi_config_bunny.sv
// Scoreboard bench: expected bytes are queued as stimulus is applied and two
// pin-level monitors decode SPI bytes (CLK_DIV=1 and CLK_DIV=4 instances).
module tb_spi_config_bunny;
    logic       clk = 1'b0;
    logic       Reset = 1'b0;
    logic [3:0] draw_a = 4'd0, hunger_a = 4'd3;
    logic [3:0] draw_b = 4'd2, hunger_b = 4'd15;
    logic       mosi_a, sclk_a, sce_a, dc_a;
    logic       mosi_b, sclk_b, sce_b, dc_b;
    int         tests = 0, fails = 0;
    logic [8:0] q_a[$];
    logic [8:0] q_b[$];
    bit         mon_en = 1'b1;

    // Sprite 1 drawn as {bank, first col, last col, byte}; later rows override earlier ones.
    int spans [10][4] = '{
        '{0, 30, 33, 'hF0}, '{0, 50, 53, 'hF0},
        '{1, 30, 33, 'hFF}, '{1, 50, 53, 'hFF},
        '{2, 26, 57, 'hFF}, '{2, 34, 35, 'hE7}, '{2, 48, 49, 'hE7},
        '{3, 26, 57, 'hFF},
        '{4, 28, 33, 'h0F}, '{4, 50, 55, 'h0F}
    };

    always #5 clk = ~clk;

    spi_config_bunny #(.CLK_DIV(1), .INIT_DELAY(16)) dut_a (
        .clock(clk), .Reset(Reset), .nivel_hambre(hunger_a), .draw(draw_a),
        .mosi(mosi_a), .sclk(sclk_a), .sce(sce_a), .dc(dc_a)
    );

    spi_config_bunny dut_b (
        .clock(clk), .Reset(Reset), .nivel_hambre(hunger_b), .draw(draw_b),
        .mosi(mosi_b), .sclk(sclk_b), .sce(sce_b), .dc(dc_b)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model(input int dr, input int h, input int b, input int c);
        logic [7:0] v;
        v = 8'h00;
        if (b == 5) return (c < 5 * h) ? 8'h3C : 8'h00;
        if (dr == 2) return (c % 2 == 1) ? 8'h55 : 8'hAA;
        if (dr == 1)
            for (int i = 0; i < 10; i++)
                if (spans[i][0] == b && c >= spans[i][1] && c <= spans[i][2])
                    v = 8'(spans[i][3]);
        return v;
    endfunction

    task automatic push(input int d, input logic [8:0] v);
        if (d == 0) q_a.push_back(v);
        else        q_b.push_back(v);
    endtask

    task automatic push_init(input int d);
        push(d, 9'h021); push(d, 9'h0BF); push(d, 9'h004);
        push(d, 9'h014); push(d, 9'h020); push(d, 9'h00C);
    endtask

    task automatic push_frame(input int d, input int dr, input int h);
        push(d, 9'h080);
        push(d, 9'h040);
        for (int b = 0; b < 6; b++)
            for (int c = 0; c < 84; c++)
                push(d, {1'b1, model(dr, h, b, c)});
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q_a.size() : q_b.size();
    endfunction

    task automatic monitor(input int d);
        int         cd, nbits, run, gap, nbyte;
        logic       s_sclk, s_sce, s_mosi, s_dc;
        logic       p_sclk, p_sce, p_mosi, dc0;
        logic [7:0] sh;
        logic [8:0] expv;
        bit         ok, gap_ok, seen;
        cd = (d == 0) ? 1 : 4;
        p_sclk = 1'b0; p_sce = 1'b1; p_mosi = 1'b0; dc0 = 1'b0; sh = 8'h00;
        nbits = 0; run = 0; gap = 0; nbyte = 0; ok = 1'b1; gap_ok = 1'b1; seen = 1'b0;
        forever begin
            @(negedge clk);
            if (d == 0) begin
                s_sclk = sclk_a; s_sce = sce_a; s_mosi = mosi_a; s_dc = dc_a;
            end else begin
                s_sclk = sclk_b; s_sce = sce_b; s_mosi = mosi_b; s_dc = dc_b;
            end
            if (mon_en) begin
                if (!s_sce) begin
                    if (p_sce) begin
                        ok = gap_ok && (!seen || gap >= 2 * cd) && !s_sclk;
                        seen = 1'b1; nbits = 0; sh = 8'h00; run = 1; dc0 = s_dc;
                    end else begin
                        if (s_dc !== dc0) ok = 1'b0;
                        if (s_sclk === p_sclk) begin
                            run++;
                            if (s_sclk && s_mosi !== p_mosi) ok = 1'b0;
                        end else begin
                            if (p_sclk) begin
                                if (run != cd) ok = 1'b0;
                            end else if (run != ((nbits == 0) ? cd + 1 : cd)) begin
                                ok = 1'b0;
                            end
                            run = 1;
                            if (s_sclk) begin
                                sh = {sh[6:0], s_mosi};
                                nbits++;
                            end
                        end
                    end
                end else begin
                    if (!p_sce) begin
                        if (!(p_sclk && run == cd && nbits == 8)) ok = 1'b0;
                        tests++;
                        if (!ok) begin
                            fails++;
                            $display("FAIL framing dut%0d byte %0d: bits=%0d last_run=%0d, expected 8 bits, phases of %0d clocks",
                                     d, nbyte, nbits, run, cd);
                        end
                        tests++;
                        if (qsize(d) == 0) begin
                            fails++;
                            $display("FAIL byte dut%0d #%0d: got dc=%0b data=0x%02h, expected no byte",
                                     d, nbyte, dc0, sh);
                        end else begin
                            expv = (d == 0) ? q_a.pop_front() : q_b.pop_front();
                            if ({dc0, sh} !== expv) begin
                                fails++;
                                $display("FAIL byte dut%0d #%0d: got dc=%0b data=0x%02h, expected dc=%0b data=0x%02h",
                                         d, nbyte, dc0, sh, expv[8], expv[7:0]);
                            end
                        end
                        nbyte++;
                        gap = 0;
                        gap_ok = 1'b1;
                    end
                    gap++;
                    if (s_sclk) gap_ok = 1'b0;
                end
            end
            p_sclk = s_sclk; p_sce = s_sce; p_mosi = s_mosi;
        end
    endtask

    task automatic wait_drain(input int d, input int budget, input string name);
        int n;
        n = 0;
        while (qsize(d) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, qsize(d), 0);
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fall_a, fall_b, n;
        Reset = 1'b0;
        repeat (100) begin
            @(negedge clk);
            check("reset_pins_a", {sce_a, sclk_a, mosi_a, dc_a}, 4'b1000);
            check("reset_pins_b", {sce_b, sclk_b, mosi_b, dc_b}, 4'b1000);
        end
        push_init(0); push_frame(0, 0, 3);
        push_init(1); push_frame(1, 2, 15);
        Reset = 1'b1;
        fall_a = -1; fall_b = -1;
        for (int k = 1; k <= 100 && (fall_a < 0 || fall_b < 0); k++) begin
            @(negedge clk);
            if (fall_a < 0 && !sce_a) fall_a = k;
            if (fall_b < 0 && !sce_b) fall_b = k;
        end
        check("first_sce_fall_a", fall_a, 16);
        check("first_sce_fall_b", fall_b, 16);

        wait_drain(0, 15000, "blank_frame_drain");
        repeat (40) @(negedge clk);
        check("idle_after_blank", {sce_a, sclk_a}, 2'b10);

        draw_a = 4'd1;
        push_frame(0, 1, 3);
        n = 0;
        while (sce_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n < 1 || n > 3) begin
            fails++;
            $display("FAIL redraw_latency: got %0d clocks, expected 1..3", n);
        end

        n = 0;
        while (q_a.size() > 300 && n < 10000) begin
            @(negedge clk);
            n++;
        end
        check("reach_mid_frame", (q_a.size() <= 300) ? 1 : 0, 1);
        hunger_a = 4'd15;
        push_frame(0, 1, 15);
        wait_drain(0, 25000, "mid_change_drain");
        repeat (40) @(negedge clk);
        check("idle_after_redraw", {sce_a, sclk_a}, 2'b10);

        wait_drain(1, 40000, "div4_frame_drain");
        repeat (100) @(negedge clk);
        check("idle_div4", {sce_b, sclk_b}, 2'b10);

        mon_en = 1'b0;
        draw_a = 4'd4;
        n = 0;
        while (!(sce_a == 1'b0 && sclk_a == 1'b1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_byte_reached", {sce_a, sclk_a}, 2'b01);
        #2 Reset = 1'b0;
        #1;
        check("async_reset_a", {sce_a, sclk_a, mosi_a, dc_a}, 4'b1000);
        check("async_reset_b", {sce_b, sclk_b, mosi_b, dc_b}, 4'b1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
